pipeline_hazard_ctrl: RTL and testbench

//  Stall/flush/freeze sequencer for the 5-stage RV32I pipeline; companion to the EX/MEM forwarding logic.

---
 rtl/pipeline_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage RV32I pipeline.
// Decodes load-use and branch-operand hazards at ID, flushes IF/ID on taken
// branches, freezes the pipe while data memory is busy (bounded by a timeout)
// and counts the cycles in which the PC did not advance.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic             IF_ID_UsesRs2,
  input  logic             IF_ID_IsBranch,
  input  logic             BranchTaken,
  input  logic [4:0]       ID_EX_Rd,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             DMemReady,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             PipeHold,
  output logic [CNT_W-1:0] StallCycles,
  output logic             MemTimeout
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, STALL_B, MEMWAIT} state_t;
  typedef enum logic [1:0] {ACT_ADV, ACT_STALL, ACT_FREEZE, ACT_FLUSH} act_t;

  state_t          state, state_nxt;
  act_t            act;
  logic [WC_W-1:0] waitcnt, waitcnt_nxt;
  logic            pending, pending_nxt;
  logic            timeout_hit;
  logic            forced;
  logic            mem_busy, match, load_use, br_dep;

  // Saturating increment: the stall counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Hazard terms; x0 never matches so it cannot create a dependency.
  always_comb begin
    mem_busy = (EX_MEM_MemRead | EX_MEM_MemWrite) & ~DMemReady;
    match    = (ID_EX_Rd != 5'd0) &
               ((ID_EX_Rd == IF_ID_Rs1) | (IF_ID_UsesRs2 & (ID_EX_Rd == IF_ID_Rs2)));
    load_use = ID_EX_MemRead & match;
    br_dep   = IF_ID_IsBranch & ID_EX_RegWrite & ~ID_EX_MemRead & match;
  end

  // Next-state and action selection, priority memBusy > forced bubble > hazards > branch.
  always_comb begin
    act         = ACT_ADV;
    state_nxt   = RUN;
    waitcnt_nxt = '0;
    pending_nxt = 1'b0;
    timeout_hit = 1'b0;
    // A forced second bubble is owed in STALL_B, or after a wait that began there.
    forced      = (state == STALL_B) || ((state == MEMWAIT) && pending);
    if ((state == MEMWAIT) && mem_busy) begin
      if (waitcnt == WC_W'(MEM_TIMEOUT)) begin
        // Forced release drops any owed bubble and lets the pipe move.
        timeout_hit = 1'b1;
        act         = ACT_ADV;
      end else begin
        act         = ACT_FREEZE;
        state_nxt   = MEMWAIT;
        waitcnt_nxt = waitcnt + WC_W'(1);
        pending_nxt = pending;
      end
    end else if (mem_busy) begin
      act         = ACT_FREEZE;
      state_nxt   = MEMWAIT;
      waitcnt_nxt = WC_W'(1);
      pending_nxt = forced;
    end else if (forced) begin
      act = ACT_STALL;
    end else if (load_use & IF_ID_IsBranch) begin
      // Branch compares in ID, so it needs the load value from WB: two bubbles.
      act       = ACT_STALL;
      state_nxt = STALL_B;
    end else if (load_use | br_dep) begin
      // Stale comparator operands: the branch outcome is ignored this cycle.
      act = ACT_STALL;
    end else if (IF_ID_IsBranch & BranchTaken) begin
      act = ACT_FLUSH;
    end
  end

  // Output decode; reset holds the front end with a bubble into ID/EX.
  always_comb begin
    PCWrite      = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    PipeHold     = 1'b0;
    if (!rst_n) begin
      ID_EX_Bubble = 1'b1;
    end else begin
      case (act)
        ACT_ADV: begin
          PCWrite     = 1'b1;
          IF_ID_Write = 1'b1;
        end
        ACT_FLUSH: begin
          PCWrite     = 1'b1;
          IF_ID_Write = 1'b1;
          IF_ID_Flush = 1'b1;
        end
        ACT_STALL:  ID_EX_Bubble = 1'b1;
        ACT_FREEZE: PipeHold     = 1'b1;
        default: ;
      endcase
    end
  end

  // State, wait counter, pending flag, stall counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      waitcnt     <= '0;
      pending     <= 1'b0;
      StallCycles <= '0;
      MemTimeout  <= 1'b0;
    end else begin
      state   <= state_nxt;
      waitcnt <= waitcnt_nxt;
      pending <= pending_nxt;
      if (!PCWrite) StallCycles <= sat_inc(StallCycles);
      if (timeout_hit) MemTimeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios followed by random traffic,
// all checked against a behavioural model of owed bubbles and memory waits.
module tb_pipeline_hazard_ctrl;

  localparam int TO = 16;

  logic       clk;
  logic       rst_n;
  logic [4:0] IF_ID_Rs1, IF_ID_Rs2, ID_EX_Rd;
  logic       IF_ID_UsesRs2, IF_ID_IsBranch, BranchTaken;
  logic       ID_EX_RegWrite, ID_EX_MemRead;
  logic       EX_MEM_MemRead, EX_MEM_MemWrite, DMemReady;

  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, PipeHold, MemTimeout;
  logic [31:0] StallCycles;
  logic        s_PCWrite, s_IF_ID_Write, s_IF_ID_Flush, s_ID_EX_Bubble, s_PipeHold, s_MemTimeout;
  logic [2:0]  s_StallCycles;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2), .IF_ID_UsesRs2(IF_ID_UsesRs2),
    .IF_ID_IsBranch(IF_ID_IsBranch), .BranchTaken(BranchTaken),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite), .DMemReady(DMemReady),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .PipeHold(PipeHold),
    .StallCycles(StallCycles), .MemTimeout(MemTimeout)
  );

  // Narrow-counter copy exercises saturation.
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2), .IF_ID_UsesRs2(IF_ID_UsesRs2),
    .IF_ID_IsBranch(IF_ID_IsBranch), .BranchTaken(BranchTaken),
    .ID_EX_Rd(ID_EX_Rd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite), .DMemReady(DMemReady),
    .PCWrite(s_PCWrite), .IF_ID_Write(s_IF_ID_Write), .IF_ID_Flush(s_IF_ID_Flush),
    .ID_EX_Bubble(s_ID_EX_Bubble), .PipeHold(s_PipeHold),
    .StallCycles(s_StallCycles), .MemTimeout(s_MemTimeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, PipeHold}
  localparam logic [4:0] O_ADV    = 5'b11000;
  localparam logic [4:0] O_FLUSH  = 5'b11100;
  localparam logic [4:0] O_STALL  = 5'b00010;
  localparam logic [4:0] O_FREEZE = 5'b00001;
  localparam logic [4:0] O_RESET  = 5'b00010;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: cycles already spent waiting (0 = not waiting), owed bubble,
  // total stalled cycles, sticky timeout.
  int     m_wait   = 0;
  bit     m_owed   = 0;
  longint m_stalls = 0;
  bit     m_tout   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    IF_ID_Rs1 = 0; IF_ID_Rs2 = 0; IF_ID_UsesRs2 = 0; IF_ID_IsBranch = 0; BranchTaken = 0;
    ID_EX_Rd = 0; ID_EX_RegWrite = 0; ID_EX_MemRead = 0;
    EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0; DMemReady = 1;
  endtask

  // One clock: predict outputs from the current inputs, check, clock, check counters.
  task automatic tick(input string tag);
    bit busy, dep, lu, bd;
    logic [4:0] e;
    int nw; bit no; bit nt;
    #1;
    busy = (EX_MEM_MemRead || EX_MEM_MemWrite) && !DMemReady;
    dep  = (ID_EX_Rd != 0) &&
           (ID_EX_Rd == IF_ID_Rs1 || (IF_ID_UsesRs2 && ID_EX_Rd == IF_ID_Rs2));
    lu   = ID_EX_MemRead && dep;
    bd   = IF_ID_IsBranch && ID_EX_RegWrite && !ID_EX_MemRead && dep;
    nw = 0; no = 0; nt = m_tout;
    if (!rst_n)                          e = O_RESET;
    else if (m_wait > 0 && busy && m_wait == TO) begin e = O_ADV; nt = 1; end
    else if (m_wait > 0 && busy)        begin e = O_FREEZE; nw = m_wait + 1; no = m_owed; end
    else if (busy)                      begin e = O_FREEZE; nw = 1; no = m_owed; end
    else if (m_owed)                     e = O_STALL;
    else if (lu && IF_ID_IsBranch)      begin e = O_STALL; no = 1; end
    else if (lu || bd)                   e = O_STALL;
    else if (IF_ID_IsBranch && BranchTaken) e = O_FLUSH;
    else                                 e = O_ADV;
    chk({tag, ".out"}, {59'd0, PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, PipeHold},
        {59'd0, e});
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_wait = 0; m_owed = 0; m_stalls = 0; m_tout = 0;
    end else begin
      m_wait = nw; m_owed = no; m_tout = nt;
      if (!e[4]) m_stalls++;
    end
    chk({tag, ".cnt"}, {32'd0, StallCycles}, m_stalls);
    chk({tag, ".cnt_sat"}, {61'd0, s_StallCycles}, (m_stalls > 7) ? 64'd7 : m_stalls);
    chk({tag, ".tout"}, {63'd0, MemTimeout}, {63'd0, m_tout});
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick("reset");
    tick("reset2");
    rst_n = 1'b1;

    // lw x5 ; add x6,x5,x7
    ID_EX_Rd = 5; ID_EX_RegWrite = 1; ID_EX_MemRead = 1;
    IF_ID_Rs1 = 5; IF_ID_Rs2 = 7; IF_ID_UsesRs2 = 1;
    tick("lu_stall");
    ID_EX_Rd = 0; ID_EX_RegWrite = 0; ID_EX_MemRead = 0;
    tick("lu_adv");
    chk("lu_total", {32'd0, StallCycles}, 64'd1);

    // lw x5 ; beq x5,x0
    ID_EX_Rd = 5; ID_EX_RegWrite = 1; ID_EX_MemRead = 1;
    IF_ID_Rs1 = 5; IF_ID_Rs2 = 0; IF_ID_IsBranch = 1;
    tick("lub_stall1");
    ID_EX_Rd = 0; ID_EX_RegWrite = 0; ID_EX_MemRead = 0; BranchTaken = 1;
    tick("lub_stall2");
    tick("lub_flush");
    chk("lub_total", {32'd0, StallCycles}, 64'd3);

    // addi x3 ; bne x3,x4 taken
    idle_inputs();
    ID_EX_Rd = 3; ID_EX_RegWrite = 1;
    IF_ID_Rs1 = 3; IF_ID_Rs2 = 4; IF_ID_UsesRs2 = 1; IF_ID_IsBranch = 1; BranchTaken = 1;
    tick("brdep_stall");
    ID_EX_Rd = 0; ID_EX_RegWrite = 0;
    tick("brdep_flush");
    chk("brdep_total", {32'd0, StallCycles}, 64'd4);

    // sw in MEM, three cycles not ready
    idle_inputs();
    EX_MEM_MemWrite = 1; DMemReady = 0;
    for (int i = 0; i < 3; i++) tick("sw_freeze");
    DMemReady = 1;
    tick("sw_release");
    chk("sw_total", {32'd0, StallCycles}, 64'd7);

    // STALL_B interrupted by a busy memory for two cycles
    idle_inputs();
    ID_EX_Rd = 5; ID_EX_MemRead = 1; ID_EX_RegWrite = 1; IF_ID_Rs1 = 5; IF_ID_IsBranch = 1;
    tick("sb_stall");
    ID_EX_Rd = 0; ID_EX_MemRead = 0; ID_EX_RegWrite = 0;
    EX_MEM_MemRead = 1; DMemReady = 0;
    tick("sb_freeze1");
    tick("sb_freeze2");
    DMemReady = 1;
    tick("sb_owed");
    tick("sb_adv");
    chk("sb_total", {32'd0, StallCycles}, 64'd11);

    // Memory never ready: forced release after the timeout
    idle_inputs();
    EX_MEM_MemRead = 1; DMemReady = 0;
    for (int i = 0; i < TO; i++) tick("to_freeze");
    tick("to_release");
    chk("to_flag", {63'd0, MemTimeout}, 64'd1);
    tick("to_reenter");
    DMemReady = 1;
    tick("to_ready");
    chk("to_sticky", {63'd0, MemTimeout}, 64'd1);

    // x0 never creates a hazard
    idle_inputs();
    ID_EX_MemRead = 1; ID_EX_RegWrite = 1; IF_ID_UsesRs2 = 1; IF_ID_IsBranch = 1;
    tick("x0_noHaz");

    // Reset in the middle of a memory wait
    idle_inputs();
    EX_MEM_MemWrite = 1; DMemReady = 0;
    tick("rw_freeze1");
    tick("rw_freeze2");
    rst_n = 1'b0;
    #1;
    chk("rw_async_cnt", {32'd0, StallCycles}, 64'd0);
    chk("rw_async_tout", {63'd0, MemTimeout}, 64'd0);
    tick("rw_reset");
    rst_n = 1'b1;
    tick("rw_after");

    // Random traffic with small register numbers so dependencies are frequent
    for (int c = 0; c < 3000; c++) begin
      IF_ID_Rs1       = 5'($urandom_range(0, 3));
      IF_ID_Rs2       = 5'($urandom_range(0, 3));
      IF_ID_UsesRs2   = 1'($urandom_range(0, 1));
      IF_ID_IsBranch  = ($urandom_range(0, 2) == 0);
      BranchTaken     = 1'($urandom_range(0, 1));
      ID_EX_Rd        = 5'($urandom_range(0, 3));
      ID_EX_RegWrite  = ($urandom_range(0, 3) != 0);
      ID_EX_MemRead   = ($urandom_range(0, 2) == 0);
      EX_MEM_MemRead  = ($urandom_range(0, 4) == 0);
      EX_MEM_MemWrite = ($urandom_range(0, 4) == 0);
      DMemReady       = (c % 500 > 440) ? 1'b0 : ($urandom_range(0, 2) != 0);
      rst_n           = ($urandom_range(0, 199) != 0);
      tick("rand");
      rst_n = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
